// File: rtl/reorder_commit_unit.sv
// reorder_commit_unit
// In-order retirement buffer between dispatch/writeback and the rename unit.
// Allocates up to four entries per cycle in slot order, records completion
// from two writeback ports, and retires at most one instruction per cycle
// from the head. Retiring a mispredicted branch raises Branch_flush and
// empties the buffer.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   Dispatch_en              dispatch group presented, rename not stalled
//   InstN_Valid/RegW/Rdst/RPhydst (N=1..4)  dispatch slot contents
//   InstN_RobIdx             entry allocated to slot N (combinational)
//   ROB_Stall                fewer than four entries free
//   WBk_Valid/RobIdx/Mispredict (k=1,2)     writeback ports
//   Commit, Commit_Phy, Commit_Rdst         rename-unit commit interface
//   Branch_flush             retiring instruction mispredicted
//   Rob_Count                occupied entries
module reorder_commit_unit #(
    parameter int DEPTH = 16,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Dispatch_en,
    input  logic             Inst1_Valid,
    input  logic             Inst1_RegW,
    input  logic [4:0]       Inst1_Rdst,
    input  logic [5:0]       Inst1_RPhydst,
    output logic [IDX_W-1:0] Inst1_RobIdx,
    input  logic             Inst2_Valid,
    input  logic             Inst2_RegW,
    input  logic [4:0]       Inst2_Rdst,
    input  logic [5:0]       Inst2_RPhydst,
    output logic [IDX_W-1:0] Inst2_RobIdx,
    input  logic             Inst3_Valid,
    input  logic             Inst3_RegW,
    input  logic [4:0]       Inst3_Rdst,
    input  logic [5:0]       Inst3_RPhydst,
    output logic [IDX_W-1:0] Inst3_RobIdx,
    input  logic             Inst4_Valid,
    input  logic             Inst4_RegW,
    input  logic [4:0]       Inst4_Rdst,
    input  logic [5:0]       Inst4_RPhydst,
    output logic [IDX_W-1:0] Inst4_RobIdx,
    output logic             ROB_Stall,
    input  logic             WB1_Valid,
    input  logic [IDX_W-1:0] WB1_RobIdx,
    input  logic             WB1_Mispredict,
    input  logic             WB2_Valid,
    input  logic [IDX_W-1:0] WB2_RobIdx,
    input  logic             WB2_Mispredict,
    output logic             Commit,
    output logic [5:0]       Commit_Phy,
    output logic [4:0]       Commit_Rdst,
    output logic             Branch_flush,
    output logic [IDX_W:0]   Rob_Count
);

    // Entry storage
    logic [DEPTH-1:0] e_valid;
    logic [DEPTH-1:0] e_done;
    logic [DEPTH-1:0] e_mispred;
    logic [DEPTH-1:0] e_regw;
    logic [4:0]       e_rdst [DEPTH];
    logic [5:0]       e_phy  [DEPTH];

    logic [IDX_W-1:0] head;
    logic [IDX_W-1:0] tail;
    logic [IDX_W:0]   count;

    // Dispatch slots gathered into arrays, slot 1 at index 0
    logic [3:0]       slot_valid;
    logic [3:0]       slot_regw;
    logic [4:0]       slot_rdst [4];
    logic [5:0]       slot_phy  [4];
    logic [2:0]       slot_off  [4];
    logic [IDX_W-1:0] slot_idx  [4];
    logic [2:0]       n_valid;
    logic [2:0]       n_disp;
    logic             fire;

    // Writeback ports gathered into arrays
    logic [1:0]       wb_valid;
    logic [1:0]       wb_mis;
    logic [IDX_W-1:0] wb_idx [2];
    logic [DEPTH-1:0] wb_done_set;
    logic [DEPTH-1:0] wb_mis_set;

    assign slot_valid  = {Inst4_Valid, Inst3_Valid, Inst2_Valid, Inst1_Valid};
    assign slot_regw   = {Inst4_RegW, Inst3_RegW, Inst2_RegW, Inst1_RegW};
    assign slot_rdst[0] = Inst1_Rdst;
    assign slot_rdst[1] = Inst2_Rdst;
    assign slot_rdst[2] = Inst3_Rdst;
    assign slot_rdst[3] = Inst4_Rdst;
    assign slot_phy[0]  = Inst1_RPhydst;
    assign slot_phy[1]  = Inst2_RPhydst;
    assign slot_phy[2]  = Inst3_RPhydst;
    assign slot_phy[3]  = Inst4_RPhydst;

    assign wb_valid  = {WB2_Valid, WB1_Valid};
    assign wb_mis    = {WB2_Mispredict, WB1_Mispredict};
    assign wb_idx[0] = WB1_RobIdx;
    assign wb_idx[1] = WB2_RobIdx;

    // Each slot's index is tail plus the number of valid slots ahead of it;
    // invalid slots do not consume an index but still see a defined value.
    always_comb begin
        logic [2:0] off;
        off = '0;
        for (int i = 0; i < 4; i++) begin
            slot_off[i] = off;
            slot_idx[i] = tail + IDX_W'(off);
            off = off + {2'b00, slot_valid[i]};
        end
        n_valid = off;
    end

    assign Inst1_RobIdx = slot_idx[0];
    assign Inst2_RobIdx = slot_idx[1];
    assign Inst3_RobIdx = slot_idx[2];
    assign Inst4_RobIdx = slot_idx[3];

    // Stall looks only at the registered count, so a commit in the same
    // cycle does not open room for a group until the next cycle.
    assign ROB_Stall = (count > (IDX_W+1)'(DEPTH - 4));

    assign Commit       = e_valid[head] & e_done[head];
    assign Branch_flush = Commit & e_mispred[head];
    assign Commit_Phy   = (Commit & e_regw[head]) ? e_phy[head]  : 6'd0;
    assign Commit_Rdst  = (Commit & e_regw[head]) ? e_rdst[head] : 5'd0;
    assign Rob_Count    = count;

    assign fire   = Dispatch_en & ~ROB_Stall & ~Branch_flush;
    assign n_disp = fire ? n_valid : 3'd0;

    // Merge both writeback ports per entry so two hits on one index OR
    // together instead of one overwriting the other.
    always_comb begin
        wb_done_set = '0;
        wb_mis_set  = '0;
        for (int k = 0; k < 2; k++) begin
            if (wb_valid[k] && e_valid[wb_idx[k]]) begin
                wb_done_set[wb_idx[k]] = 1'b1;
                wb_mis_set[wb_idx[k]]  = wb_mis_set[wb_idx[k]] | wb_mis[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            e_valid   <= '0;
            e_done    <= '0;
            e_mispred <= '0;
            e_regw    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                e_rdst[i] <= '0;
                e_phy[i]  <= '0;
            end
        end else if (Branch_flush) begin
            // Everything younger than the branch is discarded; same-cycle
            // dispatch is blocked via fire and writebacks are dropped here.
            e_valid   <= '0;
            e_done    <= '0;
            e_mispred <= '0;
            head      <= head + 1'b1;
            tail      <= head + 1'b1;
            count     <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wb_done_set[i]) e_done[i] <= 1'b1;
                if (wb_mis_set[i])  e_mispred[i] <= 1'b1;
            end
            // Retire clear comes after writeback so it wins on the head.
            if (Commit) begin
                e_valid[head]   <= 1'b0;
                e_done[head]    <= 1'b0;
                e_mispred[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            // Dispatch only targets free entries, never the retiring head.
            if (fire) begin
                for (int i = 0; i < 4; i++) begin
                    if (slot_valid[i]) begin
                        e_valid[slot_idx[i]]   <= 1'b1;
                        e_done[slot_idx[i]]    <= 1'b0;
                        e_mispred[slot_idx[i]] <= 1'b0;
                        e_regw[slot_idx[i]]    <= slot_regw[i];
                        e_rdst[slot_idx[i]]    <= slot_rdst[i];
                        e_phy[slot_idx[i]]     <= slot_phy[i];
                    end
                end
                tail <= tail + IDX_W'(n_valid);
            end
            count <= count + (IDX_W+1)'(n_disp) - (IDX_W+1)'(Commit);
        end
    end

endmodule

// File: tb/tb_reorder_commit_unit.sv
module tb_reorder_commit_unit;

    logic       clk;
    logic       rst;
    logic       Dispatch_en;
    logic [3:0] vld;
    logic [3:0] rw;
    logic [4:0] rd   [4];
    logic [5:0] ph   [4];
    logic [3:0] ridx [4];
    logic       ROB_Stall;
    logic       WB1_Valid, WB1_Mispredict, WB2_Valid, WB2_Mispredict;
    logic [3:0] WB1_RobIdx, WB2_RobIdx;
    logic       Commit, Branch_flush;
    logic [5:0] Commit_Phy;
    logic [4:0] Commit_Rdst;
    logic [4:0] Rob_Count;

    int vecs = 0;
    int errs = 0;

    typedef struct {
        logic [5:0] phy;
        logic [4:0] rdst;
        logic       fl;
    } exp_t;
    exp_t q[$];

    reorder_commit_unit #(.DEPTH(16), .IDX_W(4)) dut (
        .clk(clk), .rst(rst), .Dispatch_en(Dispatch_en),
        .Inst1_Valid(vld[0]), .Inst1_RegW(rw[0]), .Inst1_Rdst(rd[0]), .Inst1_RPhydst(ph[0]), .Inst1_RobIdx(ridx[0]),
        .Inst2_Valid(vld[1]), .Inst2_RegW(rw[1]), .Inst2_Rdst(rd[1]), .Inst2_RPhydst(ph[1]), .Inst2_RobIdx(ridx[1]),
        .Inst3_Valid(vld[2]), .Inst3_RegW(rw[2]), .Inst3_Rdst(rd[2]), .Inst3_RPhydst(ph[2]), .Inst3_RobIdx(ridx[2]),
        .Inst4_Valid(vld[3]), .Inst4_RegW(rw[3]), .Inst4_Rdst(rd[3]), .Inst4_RPhydst(ph[3]), .Inst4_RobIdx(ridx[3]),
        .ROB_Stall(ROB_Stall),
        .WB1_Valid(WB1_Valid), .WB1_RobIdx(WB1_RobIdx), .WB1_Mispredict(WB1_Mispredict),
        .WB2_Valid(WB2_Valid), .WB2_RobIdx(WB2_RobIdx), .WB2_Mispredict(WB2_Mispredict),
        .Commit(Commit), .Commit_Phy(Commit_Phy), .Commit_Rdst(Commit_Rdst),
        .Branch_flush(Branch_flush), .Rob_Count(Rob_Count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [5:0] p, input logic [4:0] r, input logic f);
        exp_t e;
        e.phy = p; e.rdst = r; e.fl = f;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        Dispatch_en = 0; vld = '0; rw = '0;
        for (int k = 0; k < 4; k++) begin rd[k] = '0; ph[k] = '0; end
        WB1_Valid = 0; WB1_RobIdx = '0; WB1_Mispredict = 0;
        WB2_Valid = 0; WB2_RobIdx = '0; WB2_Mispredict = 0;
    endtask

    // Drive a dispatch group; slot k gets rdst rd0+k and phy ph0+k.
    task automatic disp(input logic [3:0] v, input logic [3:0] w, input int rd0, input int ph0, input bit track);
        Dispatch_en = 1;
        for (int k = 0; k < 4; k++) begin
            vld[k] = v[k]; rw[k] = w[k];
            rd[k] = 5'(rd0 + k); ph[k] = 6'(ph0 + k);
            if (track && v[k]) push(w[k] ? 6'(ph0 + k) : 6'd0, w[k] ? 5'(rd0 + k) : 5'd0, 1'b0);
        end
    endtask

    task automatic disp_go(input logic [3:0] v, input logic [3:0] w, input int rd0, input int ph0);
        disp(v, w, rd0, ph0, 1'b1);
        tick();
        clr();
    endtask

    task automatic wb(input bit v1, input int i1, input bit m1, input bit v2, input int i2);
        WB1_Valid = v1; WB1_RobIdx = 4'(i1); WB1_Mispredict = m1;
        WB2_Valid = v2; WB2_RobIdx = 4'(i2); WB2_Mispredict = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && Rob_Count != 0; i++) tick();
        chk("drain_count", Rob_Count, 0);
    endtask

    // Scoreboard monitor: every retirement is matched against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (Commit) begin
                if (q.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL unexpected_commit: phy %0d rdst %0d, queue empty", Commit_Phy, Commit_Rdst);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("commit_phy", Commit_Phy, e.phy);
                    chk("commit_rdst", Commit_Rdst, e.rdst);
                    chk("commit_flush", Branch_flush, e.fl);
                end
            end else begin
                chk("idle_outputs", {Branch_flush, Commit_Phy, Commit_Rdst}, 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        clr();
        rst = 1;
        repeat (3) tick();
        rst = 0;
        tick();

        // Reset / idle
        chk("rst_commit", Commit, 0);
        chk("rst_flush", Branch_flush, 0);
        chk("rst_count", Rob_Count, 0);
        chk("rst_stall", ROB_Stall, 0);
        vld = 4'b1111; #1;
        chk("rst_idx1", ridx[0], 0);
        chk("rst_idx2", ridx[1], 1);
        chk("rst_idx3", ridx[2], 2);
        chk("rst_idx4", ridx[3], 3);
        clr();

        // Four RegW instructions, out-of-order writeback 3,1,0,2
        disp_go(4'b1111, 4'b1111, 1, 8);
        chk("d4_count", Rob_Count, 4);
        wb(1, 3, 0, 0, 0); tick(); clr();
        chk("wb3_nocommit", Commit, 0);
        wb(1, 1, 0, 0, 0); tick(); clr();
        chk("wb1_nocommit", Commit, 0);
        wb(1, 0, 0, 0, 0); tick(); clr();
        chk("idx0_commit", Commit, 1);
        wb(1, 2, 0, 0, 0); tick(); clr();
        chk("idx1_commit", Commit, 1);
        tick();
        chk("idx2_commit", Commit, 1);
        tick();
        chk("idx3_commit", Commit, 1);
        tick();
        chk("seq_done_commit", Commit, 0);
        chk("seq_done_count", Rob_Count, 0);

        // Sparse slots at tail=5
        disp_go(4'b0001, 4'b0001, 5, 20);
        disp(4'b0101, 4'b0001, 6, 21, 1'b1); #1;
        chk("sparse_idx1", ridx[0], 5);
        chk("sparse_idx3", ridx[2], 6);
        tick(); clr();
        vld = 4'b1111; #1;
        chk("sparse_tail", ridx[0], 7);
        clr();
        wb(1, 4, 0, 1, 5); tick(); clr();
        wb(1, 6, 0, 0, 0); tick(); clr();
        drain();

        // Fill 13 entries from idx7 across the wrap
        disp_go(4'b1111, 4'b1111, 1, 30);
        disp_go(4'b1111, 4'b1111, 5, 34);
        disp_go(4'b1111, 4'b1111, 9, 38);
        disp_go(4'b0001, 4'b0001, 13, 42);
        chk("fill_count", Rob_Count, 13);
        chk("fill_stall", ROB_Stall, 1);
        disp(4'b1111, 4'b1111, 20, 50, 1'b0);
        tick();
        chk("stall_ignored", Rob_Count, 13);
        wb(1, 7, 0, 0, 0); tick();
        WB1_Valid = 0;
        chk("stall_commit", Commit, 1);
        chk("stall_held", ROB_Stall, 1);
        tick(); clr();
        chk("after_commit_count", Rob_Count, 12);
        chk("after_commit_stall", ROB_Stall, 0);
        for (int i = 0; i < 6; i++) begin
            wb(1, (8 + 2*i) % 16, 0, 1, (9 + 2*i) % 16);
            tick(); clr();
        end
        drain();

        // Mispredict flush from a clean start
        chk("q_empty_pre_flush", q.size(), 0);
        rst = 1; tick(); tick(); rst = 0;
        disp(4'b1111, 4'b1111, 1, 8, 1'b0); tick(); clr();
        push(6'd8, 5'd1, 1'b1);
        disp(4'b0011, 4'b0011, 5, 12, 1'b0); tick(); clr();
        chk("mp_count", Rob_Count, 6);
        wb(1, 0, 1, 1, 1); tick(); clr();
        chk("mp_commit", Commit, 1);
        chk("mp_flush", Branch_flush, 1);
        disp(4'b1111, 4'b1111, 20, 50, 1'b0);
        wb(1, 2, 0, 0, 0);
        tick(); clr();
        chk("flush_count", Rob_Count, 0);
        chk("flush_commit", Commit, 0);
        vld = 4'b1111; #1;
        chk("flush_tail", ridx[0], 1);
        clr();
        wb(1, 1, 0, 0, 0); tick(); clr();
        chk("late_wb_commit", Commit, 0);
        chk("late_wb_count", Rob_Count, 0);
        disp_go(4'b0001, 4'b0001, 9, 50);
        chk("post_flush_count", Rob_Count, 1);
        wb(1, 1, 0, 0, 0); tick(); clr();
        chk("post_flush_head", Commit, 1);
        tick();
        chk("post_flush_drain", Rob_Count, 0);

        // Advance head to 14, then wrap with dual writeback
        disp_go(4'b1111, 4'b1111, 1, 20);
        disp_go(4'b1111, 4'b1111, 5, 24);
        disp_go(4'b1111, 4'b1111, 9, 28);
        for (int i = 0; i < 6; i++) begin
            wb(1, 2 + 2*i, 0, 1, 3 + 2*i);
            tick(); clr();
        end
        drain();
        disp(4'b1111, 4'b1111, 14, 40, 1'b1); #1;
        chk("wrap_idx1", ridx[0], 14);
        chk("wrap_idx2", ridx[1], 15);
        chk("wrap_idx3", ridx[2], 0);
        chk("wrap_idx4", ridx[3], 1);
        tick(); clr();
        wb(1, 14, 0, 1, 14); tick(); clr();
        chk("dual_commit", Commit, 1);
        tick();
        chk("dual_single_retire", Commit, 0);
        chk("dual_count", Rob_Count, 3);
        wb(1, 15, 0, 1, 0); tick(); clr();
        wb(1, 1, 0, 0, 0); tick(); clr();
        drain();
        tick();
        chk("q_empty_end", q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/reorder_commit_unit.md
Name: reorder_commit_unit

Overview:
- In-order retirement buffer that sits between dispatch/writeback and the register rename unit.
- Allocates one entry per valid renamed instruction, up to 4 per cycle in slot order, and records completion from 2 writeback ports.
- Retires at most one instruction per cycle from the head and drives the rename unit's commit interface (Commit, Commit_Phy, Commit_Rdst).
- On retirement of a mispredicted branch, asserts Branch_flush and empties itself.

Parameters:
DEPTH, 16, number of entries; power of two, at least 8
IDX_W, 4, log2(DEPTH); width of every ROB index

Ports:
clk  in  1  clock
rst  in  1  reset
Dispatch_en  in  1  dispatch group is presented and the rename unit is not stalled
InstN_Valid  in  1  slot N (N=1..4) holds an instruction
InstN_RegW  in  1  slot N writes a register
InstN_Rdst  in  5  slot N architectural destination
InstN_RPhydst  in  6  slot N physical destination, from rename
InstN_RobIdx  out  IDX_W  entry allocated to slot N (combinational)
ROB_Stall  out  1  fewer than 4 entries free
WBk_Valid  in  1  writeback port k (k=1,2) completes an instruction
WBk_RobIdx  in  IDX_W  entry being completed
WBk_Mispredict  in  1  completed instruction is a mispredicted branch
Commit  out  1  head instruction retires this cycle
Commit_Phy  out  6  physical destination of the retiring instruction
Commit_Rdst  out  5  architectural destination of the retiring instruction
Branch_flush  out  1  retiring instruction mispredicted; flush the pipeline
Rob_Count  out  IDX_W+1  occupied entries

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values: head=0, tail=0, count=0, all entry valid/done/mispredict bits 0.
- Outputs in reset: Commit=0, Branch_flush=0, Commit_Phy=0, Commit_Rdst=0, ROB_Stall=0, Rob_Count=0.
- Entry fields: valid, done, mispredict, regw, rdst[4:0], phy[5:0].
- ROB_Stall = (count > DEPTH-4). It is computed from the registered count only; a same-cycle commit does not relieve it.
- Dispatch fire = Dispatch_en & !ROB_Stall & !Branch_flush.
- Index allocation on fire:
  - Valid slots take indices tail, tail+1, ... in slot order 1..4; invalid slots are skipped and do not consume an index.
  - InstN_RobIdx = tail + (number of valid slots before N), mod DEPTH. It is driven even when not firing.
- Entry write on fire: valid=1, done=0, mispredict=0, regw, rdst, phy. tail advances by the number of valid slots, mod DEPTH.
- Writeback: WBk_Valid to a valid entry sets done=1 and ORs WBk_Mispredict into mispredict.
  - Writeback to an invalid entry is ignored.
  - Both ports may hit in the same cycle, including the same index; the result is the OR of both.
- Commit is combinational from registered head state: Commit = entry[head].valid & entry[head].done.
  - With RegW=1: Commit_Phy=phy, Commit_Rdst=rdst. If rdst=0, still drive the allocated phy with Rdst=0.
  - With RegW=0: Commit_Phy=0, Commit_Rdst=0.
  - When Commit=0, Commit_Phy and Commit_Rdst are 0.
- Commit edge: the head entry is cleared, head advances by 1 mod DEPTH, and count decrements.
- A writeback in cycle t makes the entry commit-eligible in cycle t+1 at the earliest. Minimum latency is one cycle after writeback.
- Branch_flush = Commit & entry[head].mispredict, asserted in the same cycle as that Commit.
- Flush edge:
  - All entries are invalidated; head = tail = head+1; count=0.
  - Dispatch is suppressed in that cycle.
  - Writebacks arriving that cycle are dropped.
- Simultaneous dispatch and commit: count_next = count + n_valid_dispatched - Commit.
- Wrap-around: all pointer and index arithmetic is mod DEPTH. Full (count=DEPTH) and empty are distinguished by count, not by pointer equality.
- At most one retirement per cycle. A younger entry that is done waits until the head retires.

Test Plan:
- Reset then idle: Commit=0, Branch_flush=0, Rob_Count=0, ROB_Stall=0, InstN_RobIdx=0,1,2,3.
- Dispatch 4 RegW instructions (Rdst 1..4, Phy 8..11), then writeback idx 3,1,0,2 one per cycle:
  - Commit fires for idx0 in the cycle after its writeback.
  - Idx1 and idx2 then retire on consecutive cycles, and idx3 retires the cycle after idx2.
  - Commit_Phy sequence is 8,9,10,11; Commit_Rdst sequence is 1,2,3,4.
- Sparse slots: Valid=1,0,1,0 at tail=5 gives Inst1_RobIdx=5, Inst3_RobIdx=6, and tail becomes 7.
- Fill 13 entries: ROB_Stall=1 and Dispatch_en is ignored. After one commit, count=12 and ROB_Stall=0 next cycle.
- Mispredict flush:
  - Setup: 6 entries in flight; WB1 idx0 with Mispredict=1; idx1 done.
  - Next cycle: Commit=1 and Branch_flush=1.
  - Following cycle: count=0, head=tail=1, and a late WB to idx1 is ignored.
- Wrap and dual writeback:
  - Setup: head=14, dispatch 4 into idx 14,15,0,1.
  - WB1 and WB2 both target idx14 in one cycle; only one retirement follows.
  - Entries retire in order 14,15,0,1 across the wrap.
